matvec_engine: RTL and testbench

- Consumes the 72-bit packed 3x3 int8 matrix A produced by the A-load buffer, plus a stream of 3-element B column vectors.
- Computes y = A·b for each accepted column using three row MACs iterated over 3 cycles.
- Delivers the 3-element result through a valid/ready handshake to the result/readback stage.
- Buffers a newly loaded A arriving mid-computation so that A loads and compute overlap safely.

---
 rtl/matvec_engine.sv | 143 ++++++++++++++
 tb/tb_matvec_engine.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// 3x3 int8 matrix times 3-element column: three row MACs over 3 cycles; y_valid follows acceptance edge T at edge T+3.
// b_ready only in READY; y_data held until y_ready; A loads during CALC/OUT wait in a pending slot.
module matvec_engine #(
  parameter int ACC_W  = 18,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [71:0]        a_in,
  input  logic               a_load,
  input  logic               b_valid,
  input  logic [23:0]        b_data,
  output logic               b_ready,
  output logic               y_valid,
  output logic [3*ACC_W-1:0] y_data,
  input  logic               y_ready,
  output logic               a_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_CALC, S_OUT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [71:0]        r_a;
  logic [71:0]        r_pend;
  logic               r_pend_flag;
  logic [23:0]        r_b;
  logic [1:0]         r_k;
  logic [ACC_W-1:0]   r_acc [3];
  logic               r_a_loaded;

  logic               w_b_hs;
  logic               w_y_hs;
  logic [7:0]         w_a_el [3][3];
  logic [7:0]         w_b_el [3];
  logic signed [17:0] w_p18 [3];
  logic [ACC_W-1:0]   w_prod [3];

  function automatic logic signed [8:0] ext8(input logic [7:0] v);
    return (SIGNED != 0) ? {v[7], v} : {1'b0, v};
  endfunction

  assign w_b_hs   = b_valid && (r_state == S_READY);
  assign w_y_hs   = y_ready && (r_state == S_OUT);
  assign y_data   = {r_acc[0], r_acc[1], r_acc[2]};
  assign a_loaded = r_a_loaded;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    b_ready = 1'b0;
    y_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (a_load) w_next = S_READY;
      S_READY: begin
        b_ready = 1'b1;
        if (w_b_hs) w_next = S_CALC;
      end
      S_CALC:  if (r_k == 2'd2) w_next = S_OUT;
      S_OUT: begin
        y_valid = 1'b1;
        if (w_y_hs) w_next = S_READY;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Unpack row-major A (a00 in the top byte) and the column vector.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_b_el[r] = r_b[23-8*r -: 8];
      for (int c = 0; c < 3; c++) begin
        w_a_el[r][c] = r_a[71-8*(3*r+c) -: 8];
      end
    end
  end

  // 9x9 products fit an 18-bit signed value; resize sign-extends or wraps to ACC_W.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_p18[r]  = 18'(ext8(w_a_el[r][r_k])) * 18'(ext8(w_b_el[r_k]));
      w_prod[r] = ACC_W'(w_p18[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
      r_b         <= '0;
      r_k         <= '0;
      r_a_loaded  <= 1'b0;
      for (int r = 0; r < 3; r++) r_acc[r] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (a_load) begin
            r_a        <= a_in;
            r_a_loaded <= 1'b1;
          end
        end
        S_READY: begin
          if (a_load) r_a <= a_in;
          if (w_b_hs) begin
            r_b <= b_data;
            r_k <= 2'd0;
            for (int r = 0; r < 3; r++) r_acc[r] <= '0;
          end
        end
        S_CALC: begin
          for (int r = 0; r < 3; r++) r_acc[r] <= r_acc[r] + w_prod[r];
          r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
          if (a_load) begin
            r_pend      <= a_in;
            r_pend_flag <= 1'b1;
          end
        end
        S_OUT: begin
          // The in-flight column keeps the old A; swap only as we return to READY.
          if (w_y_hs) begin
            if (a_load) begin
              r_a         <= a_in;
              r_pend_flag <= 1'b0;
            end else if (r_pend_flag) begin
              r_a         <= r_pend;
              r_pend_flag <= 1'b0;
            end
          end else if (a_load) begin
            r_pend      <= a_in;
            r_pend_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Randomised self-checking bench for matvec_engine; a signed and an unsigned instance share all stimulus.
`timescale 1ns/1ps
module tb_matvec_engine;

  localparam int ACC_W = 18;
  localparam int YW    = 3*ACC_W;
  localparam logic [71:0] IDENT = 72'h01_00_00_00_01_00_00_00_01;

  logic          clk;
  logic          rst;
  logic [71:0]   a_in;
  logic          a_load;
  logic          b_valid;
  logic [23:0]   b_data;
  logic          y_ready;
  logic          b_ready, y_valid, a_loaded;
  logic [YW-1:0] y_data;
  logic          bu_ready, yu_valid, au_loaded;
  logic [YW-1:0] yu_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [71:0] cur_a;
  time         t_acc;

  matvec_engine #(.ACC_W(ACC_W), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .a_in(a_in), .a_load(a_load), .b_valid(b_valid), .b_data(b_data),
    .b_ready(b_ready), .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready), .a_loaded(a_loaded)
  );

  matvec_engine #(.ACC_W(ACC_W), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .a_in(a_in), .a_load(a_load), .b_valid(b_valid), .b_data(b_data),
    .b_ready(bu_ready), .y_valid(yu_valid), .y_data(yu_data), .y_ready(y_ready), .a_loaded(au_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: each y_r = sum_c a_rc*b_c in plain integers, wrapped to ACC_W bits.
  function automatic logic [YW-1:0] model_y(input logic [71:0] a, input logic [23:0] b, input bit sgn);
    logic [YW-1:0] y;
    logic [7:0]    ae, be;
    int            s, av, bv;
    y = '0;
    for (int r = 0; r < 3; r++) begin
      s = 0;
      for (int c = 0; c < 3; c++) begin
        ae = a[71-8*(3*r+c) -: 8];
        be = b[23-8*c -: 8];
        av = sgn ? int'($signed(ae)) : int'(ae);
        bv = sgn ? int'($signed(be)) : int'(be);
        s += av * bv;
      end
      y[YW-1-ACC_W*r -: ACC_W] = s[ACC_W-1:0];
    end
    return y;
  endfunction

  function automatic logic [71:0] rand_a();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [71:0] v);
    a_in = v;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
  endtask

  task automatic push_col(input logic [23:0] b, input bit do_load, input logic [71:0] a, output bit ok);
    int n;
    n = 0;
    b_valid = 1'b1;
    b_data  = b;
    while (!b_ready && n < 40) begin
      tick();
      n++;
    end
    ok = b_ready;
    if (do_load) begin
      a_in   = a;
      a_load = 1'b1;
    end
    tick();
    t_acc   = $time;
    b_valid = 1'b0;
    a_load  = 1'b0;
  endtask

  task automatic wait_y(output int lat);
    lat = 0;
    while (!y_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!y_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in = '0; a_load = 1'b0; b_valid = 1'b0; b_data = '0; y_ready = 1'b1;
    #2 rst = 1'b0;
    #10;
    n_checks++;
    if ({b_ready, y_valid, a_loaded} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {b_ready,y_valid,a_loaded}=%b expected 000", {b_ready, y_valid, a_loaded});
    end
    n_checks++;
    if (y_data !== '0 || yu_data !== '0) begin
      n_fail++;
      $display("FAIL reset_y: y_data=%h yu_data=%h expected 0", y_data, yu_data);
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_idle_gating();
    int bad;
    int lat;
    bad = 0;
    b_valid = 1'b1;
    b_data  = 24'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_ready || y_valid || a_loaded) bad++;
    end
    b_valid = 1'b0;
    wait_y(lat);
    n_checks++;
    if (bad != 0 || lat != -1) begin
      n_fail++;
      $display("FAIL idle_gating: bad_cycles=%0d y_wait=%0d expected 0 and -1", bad, lat);
    end
    load_a(IDENT);
    cur_a = IDENT;
    n_checks++;
    if ({a_loaded, b_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_first_load: {a_loaded,b_ready}=%b expected 11", {a_loaded, b_ready});
    end
  endtask

  task automatic test_identity();
    bit ok;
    int lat;
    push_col(24'h05_FD_7F, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (!ok || lat != 3) begin
      n_fail++;
      $display("FAIL identity_latency: accepted=%0d edges=%0d expected 1 and 3", ok, lat);
    end
    n_checks++;
    if (y_data !== {18'd5, 18'h3FFFD, 18'd127}) begin
      n_fail++;
      $display("FAIL identity_y: got %h expected %h", y_data, {18'd5, 18'h3FFFD, 18'd127});
    end
    tick();
    n_checks++;
    if ({y_valid, b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL identity_return: {y_valid,b_ready}=%b expected 01", {y_valid, b_ready});
    end
  endtask

  task automatic test_extremes();
    bit ok;
    int lat;
    load_a({9{8'h80}});
    push_col(24'h80_80_80, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (y_data !== {3{18'h0C000}} || yu_data !== {3{18'h0C000}}) begin
      n_fail++;
      $display("FAIL extreme_80: signed=%h unsigned=%h expected %h", y_data, yu_data, {3{18'h0C000}});
    end
    tick();
    load_a({9{8'hFF}});
    push_col(24'hFF_FF_FF, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (yu_data !== {3{18'h2FA03}}) begin
      n_fail++;
      $display("FAIL extreme_ff_unsigned: got %h expected %h", yu_data, {3{18'h2FA03}});
    end
    n_checks++;
    if (y_data !== {3{18'd3}}) begin
      n_fail++;
      $display("FAIL extreme_ff_signed: got %h expected %h", y_data, {3{18'd3}});
    end
    tick();
    cur_a = {9{8'hFF}};
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat, bad;
    logic [23:0]   b;
    logic [YW-1:0] exp_y;
    cur_a = rand_a();
    load_a(cur_a);
    b = 24'($urandom);
    exp_y = model_y(cur_a, b, 1'b1);
    y_ready = 1'b0;
    push_col(b, 1'b0, '0, ok);
    wait_y(lat);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      b_valid = i[0];
      b_data  = 24'($urandom);
      tick();
      if (y_valid !== 1'b1 || y_data !== exp_y || b_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || lat != 3) begin
      n_fail++;
      $display("FAIL backpressure_hold: bad_cycles=%0d latency=%0d y=%h expected 0, 3, %h", bad, lat, y_data, exp_y);
    end
    b_valid = 1'b0;
    y_ready = 1'b1;
    tick();
    n_checks++;
    if ({y_valid, b_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: {y_valid,b_ready}=%b expected 01", {y_valid, b_ready});
    end
    wait_y(lat);
    n_checks++;
    if (lat != -1) begin
      n_fail++;
      $display("FAIL backpressure_no_accept: stray result after %0d edges, expected none", lat);
    end
  endtask

  task automatic test_pending();
    bit ok;
    int lat;
    logic [23:0] b;
    logic [71:0] p1, p2;
    load_a(IDENT);
    cur_a = IDENT;
    push_col(24'h01_02_03, 1'b0, '0, ok);
    load_a({9{8'h02}});
    wait_y(lat);
    n_checks++;
    if (y_data !== {18'd1, 18'd2, 18'd3}) begin
      n_fail++;
      $display("FAIL pending_old_a: got %h expected %h", y_data, {18'd1, 18'd2, 18'd3});
    end
    tick();
    push_col(24'h01_01_01, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (y_data !== {3{18'd6}}) begin
      n_fail++;
      $display("FAIL pending_new_a: got %h expected %h", y_data, {3{18'd6}});
    end
    tick();
    cur_a = {9{8'h02}};
    // Pending P1 is overridden by a same-cycle load at the OUT->READY handshake.
    p1 = rand_a();
    p2 = rand_a();
    b = 24'($urandom);
    push_col(b, 1'b0, '0, ok);
    load_a(p1);
    wait_y(lat);
    n_checks++;
    if (y_data !== model_y(cur_a, b, 1'b1)) begin
      n_fail++;
      $display("FAIL override_inflight: got %h expected %h", y_data, model_y(cur_a, b, 1'b1));
    end
    load_a(p2);
    cur_a = p2;
    b = 24'($urandom);
    push_col(b, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (y_data !== model_y(cur_a, b, 1'b1)) begin
      n_fail++;
      $display("FAIL override_result: got %h expected %h", y_data, model_y(cur_a, b, 1'b1));
    end
    tick();
    p1 = rand_a();
    p2 = rand_a();
    push_col(b, 1'b0, '0, ok);
    load_a(p1);
    load_a(p2);
    wait_y(lat);
    tick();
    cur_a = p2;
    b = 24'($urandom);
    push_col(b, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (y_data !== model_y(cur_a, b, 1'b1)) begin
      n_fail++;
      $display("FAIL pending_last_wins: got %h expected %h", y_data, model_y(cur_a, b, 1'b1));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok, do_load;
    int lat, stall, bad_y, bad_t, bad_lat;
    time t_prev;
    logic [23:0] b;
    logic [71:0] a;
    bad_y = 0; bad_t = 0; bad_lat = 0; stall = 0;
    t_prev = 0;
    for (int i = 0; i < 16; i++) begin
      b = 24'($urandom);
      a = rand_a();
      do_load = 1'($urandom);
      push_col(b, do_load, a, ok);
      if (do_load) cur_a = a;
      if (i > 0 && (t_acc - t_prev) != 50 + 10*stall) bad_t++;
      t_prev = t_acc;
      wait_y(lat);
      if (!ok || lat != 3) bad_lat++;
      if (y_data !== model_y(cur_a, b, 1'b1) || yu_data !== model_y(cur_a, b, 1'b0)) bad_y++;
      stall = $urandom_range(0, 2);
      y_ready = 1'b0;
      for (int s = 0; s < stall; s++) tick();
      y_ready = 1'b1;
      tick();
    end
    n_checks++;
    if (bad_y != 0) begin
      n_fail++;
      $display("FAIL b2b_results: %0d of 16 columns wrong, expected 0", bad_y);
    end
    n_checks++;
    if (bad_lat != 0) begin
      n_fail++;
      $display("FAIL b2b_latency: %0d columns not at 3 edges, expected 0", bad_lat);
    end
    n_checks++;
    if (bad_t != 0) begin
      n_fail++;
      $display("FAIL b2b_interval: %0d issue intervals off, expected 0", bad_t);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int lat;
    logic [23:0] b;
    logic [71:0] f;
    push_col(24'($urandom), 1'b0, '0, ok);
    load_a(rand_a());
    rst = 1'b0;
    #1;
    n_checks++;
    if ({y_valid, b_ready, a_loaded} !== 3'b000 || y_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: {y_valid,b_ready,a_loaded}=%b y=%h expected 000 and 0",
               {y_valid, b_ready, a_loaded}, y_data);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({b_ready, a_loaded} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: {b_ready,a_loaded}=%b expected 00", {b_ready, a_loaded});
    end
    f = rand_a();
    load_a(f);
    cur_a = f;
    b = 24'($urandom);
    push_col(b, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (!ok || lat != 3 || y_data !== model_y(cur_a, b, 1'b1)) begin
      n_fail++;
      $display("FAIL reset_fresh: accepted=%0d lat=%0d y=%h expected 1, 3, %h", ok, lat, y_data, model_y(cur_a, b, 1'b1));
    end
    tick();
    b = 24'($urandom);
    push_col(b, 1'b0, '0, ok);
    wait_y(lat);
    n_checks++;
    if (y_data !== model_y(cur_a, b, 1'b1)) begin
      n_fail++;
      $display("FAIL reset_pending_dropped: got %h expected %h", y_data, model_y(cur_a, b, 1'b1));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_gating();
    test_identity();
    test_extremes();
    test_backpressure();
    test_pending();
    test_back_to_back();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
